// File: rtl/ct_spsram_4096x144_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ct_spsram_4096x144_ctrl                                      |
// | Description : Zero-fill sequencer and round-robin two-port arbiter for a   |
// |               4096x144 single-port SRAM with active-low controls.          |
// |               CT_SPSRAM_CTRL_RDATA_FLOP_EN registers rdata/rvld (+1 cycle). |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module ct_spsram_4096x144_ctrl #(
   parameter int ADDR_WIDTH    = 12,
   parameter int DATA_WIDTH    = 144,
   parameter bit INIT_ON_RESET = 1'b1
) (
   input  logic                  forever_cpuclk,
   input  logic                  cpurst_b,
   input  logic                  init_req,
   output logic                  init_busy,
   input  logic                  p0_req,
   input  logic                  p0_wr,
   input  logic [ADDR_WIDTH-1:0] p0_addr,
   input  logic [DATA_WIDTH-1:0] p0_wdata,
   input  logic [DATA_WIDTH-1:0] p0_wmask,
   output logic                  p0_gnt,
   output logic                  p0_rvld,
   input  logic                  p1_req,
   input  logic                  p1_wr,
   input  logic [ADDR_WIDTH-1:0] p1_addr,
   input  logic [DATA_WIDTH-1:0] p1_wdata,
   input  logic [DATA_WIDTH-1:0] p1_wmask,
   output logic                  p1_gnt,
   output logic                  p1_rvld,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic [ADDR_WIDTH-1:0] sram_a,
   output logic                  sram_cen,
   output logic                  sram_gwen,
   output logic [DATA_WIDTH-1:0] sram_wen,
   output logic [DATA_WIDTH-1:0] sram_d,
   input  logic [DATA_WIDTH-1:0] sram_q
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_INIT = 1'b1
   } state_t;

   localparam state_t                RESET_STATE = INIT_ON_RESET ? ST_INIT : ST_IDLE;
   localparam logic [ADDR_WIDTH-1:0] FILL_LAST   = '1;
   localparam logic [ADDR_WIDTH-1:0] FILL_ONE    = 1;

   state_t                state;
   logic [ADDR_WIDTH-1:0] fill_cnt;
   logic                  last_p1;
   logic                  rd_pend;
   logic                  rd_owner;
   logic                  arb_en;

   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         state     <= RESET_STATE;
         fill_cnt  <= '0;
         init_busy <= INIT_ON_RESET;
      end else begin
         case (state)
            ST_IDLE: begin
               if (init_req) begin
                  state     <= ST_INIT;
                  init_busy <= 1'b1;
               end
            end
            ST_INIT: begin
               if (fill_cnt == FILL_LAST) begin
                  state     <= ST_IDLE;
                  init_busy <= 1'b0;
                  fill_cnt  <= '0;
               end else begin
                  fill_cnt  <= fill_cnt + FILL_ONE;
               end
            end
            default: begin
               state     <= ST_IDLE;
               init_busy <= 1'b0;
            end
         endcase
      end
   end

   // init_req wins over both requesters in the cycle it is seen
   assign arb_en = (state == ST_IDLE) && !init_req;
   assign p0_gnt = arb_en && p0_req && (!p1_req || last_p1);
   assign p1_gnt = arb_en && p1_req && (!p0_req || !last_p1);

   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         last_p1  <= 1'b1;
         rd_pend  <= 1'b0;
         rd_owner <= 1'b0;
      end else begin
         if (p0_gnt) begin
            last_p1 <= 1'b0;
         end else if (p1_gnt) begin
            last_p1 <= 1'b1;
         end
         rd_pend  <= (p0_gnt && !p0_wr) || (p1_gnt && !p1_wr);
         rd_owner <= p1_gnt;
      end
   end

   always_comb begin
      sram_a    = '0;
      sram_d    = '0;
      sram_cen  = 1'b1;
      sram_gwen = 1'b1;
      sram_wen  = '1;
      if (state == ST_INIT) begin
         sram_a    = fill_cnt;
         sram_cen  = 1'b0;
         sram_gwen = 1'b0;
         sram_wen  = '0;
      end else if (p0_gnt) begin
         sram_a   = p0_addr;
         sram_d   = p0_wdata;
         sram_cen = 1'b0;
         if (p0_wr) begin
            sram_gwen = 1'b0;
            sram_wen  = ~p0_wmask;
         end
      end else if (p1_gnt) begin
         sram_a   = p1_addr;
         sram_d   = p1_wdata;
         sram_cen = 1'b0;
         if (p1_wr) begin
            sram_gwen = 1'b0;
            sram_wen  = ~p1_wmask;
         end
      end
   end

`ifdef CT_SPSRAM_CTRL_RDATA_FLOP_EN
   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         p0_rvld <= 1'b0;
         p1_rvld <= 1'b0;
         rdata   <= '0;
      end else begin
         p0_rvld <= rd_pend && !rd_owner;
         p1_rvld <= rd_pend && rd_owner;
         if (rd_pend) begin
            rdata <= sram_q;
         end
      end
   end
`else
   assign p0_rvld = rd_pend && !rd_owner;
   assign p1_rvld = rd_pend && rd_owner;
   assign rdata   = sram_q;
`endif

endmodule
`default_nettype wire
